// File: rtl/pll_lock_controller.sv
// PLL reset/lock sequencer: pulses the PLL reset, waits for a filtered lock,
// then releases the downstream system reset; retries on timeout or loss of lock.
//
//  state     | meaning
//  RESET_PLL | pll_rst held high for PLL_RST_CYCLES
//  WAIT_LOCK | waiting for locked_s, bounded by LOCK_TIMEOUT
//  STABILIZE | locked_s must hold for STABLE_CYCLES
//  RELEASE   | sys_rst still high for SYS_RST_DELAY
//  RUN       | ready; LOSS_FILTER low cycles means lock lost
module pll_lock_controller #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 256,
  parameter int LOSS_FILTER    = 4,
  parameter int SYS_RST_DELAY  = 32
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] loss_cnt,
  output logic       timeout_pulse
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_CD  = (STABLE_CYCLES > LOSS_FILTER) ? STABLE_CYCLES : LOSS_FILTER;
  localparam int MAX_ABCD = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_MAX = (MAX_ABCD > SYS_RST_DELAY) ? MAX_ABCD : SYS_RST_DELAY;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [CW-1:0] LAST_RST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LAST_WAIT   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] LAST_STABLE = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] LAST_LOSS   = CW'(LOSS_FILTER - 1);
  localparam logic [CW-1:0] LAST_REL    = CW'(SYS_RST_DELAY - 1);

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABILIZE = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t          st;
  state_t          nxt;
  logic [CW-1:0]   cnt;
  logic [1:0]      sync_q;
  logic            locked_s;
  logic            timeout_evt;
  logic            loss_evt;

  assign locked_s = sync_q[1];
  assign state    = st;

  always_comb begin
    nxt         = st;
    timeout_evt = 1'b0;
    loss_evt    = 1'b0;
    case (st)
      RESET_PLL: if (cnt == LAST_RST) nxt = WAIT_LOCK;
      WAIT_LOCK: begin
        // lock takes priority over a coincident timeout
        if (locked_s) nxt = STABILIZE;
        else if (cnt == LAST_WAIT) begin
          nxt         = RESET_PLL;
          timeout_evt = 1'b1;
        end
      end
      STABILIZE: begin
        if (!locked_s) nxt = WAIT_LOCK;
        else if (cnt == LAST_STABLE) nxt = RELEASE;
      end
      RELEASE: begin
        if (!locked_s) nxt = RESET_PLL;
        else if (cnt == LAST_REL) nxt = RUN;
      end
      RUN: begin
        if (!locked_s && cnt == LAST_LOSS) begin
          nxt      = RESET_PLL;
          loss_evt = 1'b1;
        end
      end
      default: nxt = RESET_PLL;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      st            <= RESET_PLL;
      cnt           <= '0;
      sync_q        <= 2'b00;
      pll_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      retry_cnt     <= 8'd0;
      loss_cnt      <= 8'd0;
      timeout_pulse <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], locked};
      st     <= nxt;
      // in RUN the shared counter doubles as the loss filter
      if (nxt != st)                cnt <= '0;
      else if (st == RUN && locked_s) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      pll_rst       <= (nxt == RESET_PLL);
      sys_rst       <= (nxt != RUN);
      ready         <= (nxt == RUN);
      timeout_pulse <= timeout_evt;
      if (timeout_evt && retry_cnt != 8'hFF) retry_cnt <= retry_cnt + 8'd1;
      if (loss_evt && loss_cnt != 8'hFF)     loss_cnt  <= loss_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_lock_controller.sv
// Directed bench for pll_lock_controller: default-parameter sequencing plus a
// short-timeout instance for retry saturation.
module tb_pll_lock_controller;

  logic       refclk;
  logic       rst, locked;
  logic       pll_rst, sys_rst, ready, timeout_pulse;
  logic [2:0] state;
  logic [7:0] retry_cnt, loss_cnt;

  logic       rst2, locked2;
  logic       pll_rst2, sys_rst2, ready2, timeout_pulse2;
  logic [2:0] state2;
  logic [7:0] retry_cnt2, loss_cnt2;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int base  = 0;
  int pulses = 0;

  pll_lock_controller dut (
    .refclk(refclk), .rst(rst), .locked(locked),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .ready(ready), .state(state),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt), .timeout_pulse(timeout_pulse)
  );

  pll_lock_controller #(
    .PLL_RST_CYCLES(2), .LOCK_TIMEOUT(4), .STABLE_CYCLES(2),
    .LOSS_FILTER(2), .SYS_RST_DELAY(2)
  ) dut_small (
    .refclk(refclk), .rst(rst2), .locked(locked2),
    .pll_rst(pll_rst2), .sys_rst(sys_rst2), .ready(ready2), .state(state2),
    .retry_cnt(retry_cnt2), .loss_cnt(loss_cnt2), .timeout_pulse(timeout_pulse2)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int target);
    while (cyc - base < target) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc - base);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"},   32'(state), 0);
    chk({tag, " pll_rst"}, 32'(pll_rst), 1);
    chk({tag, " sys_rst"}, 32'(sys_rst), 1);
    chk({tag, " ready"},   32'(ready), 0);
    chk({tag, " retry"},   32'(retry_cnt), 0);
    chk({tag, " loss"},    32'(loss_cnt), 0);
    chk({tag, " tpulse"},  32'(timeout_pulse), 0);
  endtask

  initial begin
    rst = 1'b1; locked = 1'b1; rst2 = 1'b1; locked2 = 1'b0;
    repeat (3) tick();
    chk_reset_vals("in_reset");
    rst = 1'b0;
    base = cyc;
    chk_reset_vals("cycle0");

    // power-up with lock constantly asserted
    run_to(15);  chk("c15 pll_rst", 32'(pll_rst), 1); chk("c15 state", 32'(state), 0);
    run_to(16);  chk("c16 pll_rst", 32'(pll_rst), 0); chk("c16 state", 32'(state), 1);
    run_to(17);  chk("c17 state", 32'(state), 2);
    run_to(272); chk("c272 state", 32'(state), 2);
    run_to(273); chk("c273 state", 32'(state), 3);
    run_to(304); chk("c304 state", 32'(state), 3); chk("c304 sys_rst", 32'(sys_rst), 1);
    chk("c304 ready", 32'(ready), 0);
    run_to(305); chk("c305 state", 32'(state), 4); chk("c305 sys_rst", 32'(sys_rst), 0);
    chk("c305 ready", 32'(ready), 1); chk("c305 pll_rst", 32'(pll_rst), 0);

    // 3-cycle glitch is filtered, 4-cycle loss resets the PLL
    run_to(310); locked = 1'b0;
    run_to(313); locked = 1'b1;
    run_to(315); chk("glitch state", 32'(state), 4);
    run_to(320); chk("glitch state late", 32'(state), 4); chk("glitch loss", 32'(loss_cnt), 0);
    chk("glitch ready", 32'(ready), 1);
    locked = 1'b0;
    run_to(324); locked = 1'b1;
    run_to(325); chk("loss pre state", 32'(state), 4);
    run_to(326); chk("loss state", 32'(state), 0); chk("loss sys_rst", 32'(sys_rst), 1);
    chk("loss pll_rst", 32'(pll_rst), 1); chk("loss ready", 32'(ready), 0);
    chk("loss cnt1", 32'(loss_cnt), 1);

    // single-cycle drop at STABILIZE counter 200 restarts stabilization
    run_to(342); chk("relock wait", 32'(state), 1);
    run_to(343); chk("relock stab", 32'(state), 2);
    run_to(541); locked = 1'b0;
    run_to(542); locked = 1'b1;
    run_to(543); chk("stab c200 state", 32'(state), 2);
    run_to(544); chk("stab drop state", 32'(state), 1);
    run_to(545); chk("stab reenter", 32'(state), 2);
    run_to(800); chk("stab full end", 32'(state), 2);
    run_to(801); chk("release entry", 32'(state), 3);
    run_to(832); chk("release end", 32'(state), 3);
    run_to(833); chk("run again", 32'(state), 4);

    // second loss, then reset pulse in RUN
    run_to(840); locked = 1'b0;
    run_to(844); locked = 1'b1;
    run_to(846); chk("loss2 state", 32'(state), 0); chk("loss cnt2", 32'(loss_cnt), 2);
    run_to(1151); chk("run3 state", 32'(state), 4); chk("run3 loss", 32'(loss_cnt), 2);
    run_to(1155);
    rst = 1'b1; tick(); rst = 1'b0;
    base = cyc;
    chk_reset_vals("rst_in_run");
    run_to(16);  chk("rr c16 state", 32'(state), 1);
    run_to(17);  chk("rr c17 state", 32'(state), 2);
    run_to(304); chk("rr c304 state", 32'(state), 3);
    run_to(305); chk("rr c305 state", 32'(state), 4); chk("rr c305 ready", 32'(ready), 1);

    // lock first seen at WAIT_LOCK counter 4095: lock wins
    rst = 1'b1; locked = 1'b0; tick(); rst = 1'b0;
    base = cyc;
    run_to(4109); locked = 1'b1;
    run_to(4111); chk("race state", 32'(state), 1); chk("race tpulse pre", 32'(timeout_pulse), 0);
    run_to(4112); chk("race stab", 32'(state), 2); chk("race retry", 32'(retry_cnt), 0);
    chk("race tpulse", 32'(timeout_pulse), 0);

    // plain timeout with lock never asserted
    rst = 1'b1; locked = 1'b0; tick(); rst = 1'b0;
    base = cyc;
    run_to(4111); chk("to pre state", 32'(state), 1); chk("to pre tpulse", 32'(timeout_pulse), 0);
    chk("to pre retry", 32'(retry_cnt), 0);
    run_to(4112); chk("to state", 32'(state), 0); chk("to tpulse", 32'(timeout_pulse), 1);
    chk("to retry", 32'(retry_cnt), 1); chk("to pll_rst", 32'(pll_rst), 1);
    run_to(4113); chk("to tpulse off", 32'(timeout_pulse), 0);
    run_to(4127); chk("to pll_rst last", 32'(pll_rst), 1);
    run_to(4128); chk("to pll_rst done", 32'(pll_rst), 0); chk("to wait again", 32'(state), 1);

    // retry saturation on the short-timeout instance: one timeout every 6 cycles
    rst2 = 1'b0;
    base = cyc;
    for (int i = 0; i < 1810; i++) begin
      tick();
      if (timeout_pulse2) pulses++;
    end
    chk("sat pulses", 32'(pulses), 301);
    chk("sat retry", 32'(retry_cnt2), 255);
    run_to(1817); chk("sat wait state", 32'(state2), 1);
    rst2 = 1'b1; tick(); rst2 = 1'b0;
    chk("midto state", 32'(state2), 0); chk("midto retry", 32'(retry_cnt2), 0);
    chk("midto tpulse", 32'(timeout_pulse2), 0); chk("midto pll_rst", 32'(pll_rst2), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
